// File: rtl/axi_idma_cfg_slave.sv
// AXI4 register responder for the iDMA configuration window: holds the job
// descriptor, launches a job on NEXT_ID reads and counts backend completions.
package axi_idma_cfg_pkg;
    localparam int IdW   = 7;
    localparam int AddrW = 32;
    localparam int DataW = 64;
    localparam int UserW = 1;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
    } axi_ax_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } axi_w_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } axi_rsp_t;
endpackage

module axi_idma_cfg_slave #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 7,
    parameter int unsigned AxiUserWidth = 1,
    parameter bit          IsTwoD       = 1'b0,
    parameter type axi_req_t = axi_idma_cfg_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_idma_cfg_pkg::axi_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  axi_req_t    axi_req_i,
    output axi_rsp_t    axi_rsp_o,
    output logic        job_valid_o,
    input  logic        job_ready_i,
    output logic [31:0] job_src_o,
    output logic [31:0] job_dst_o,
    output logic [31:0] job_len_o,
    output logic [31:0] job_conf_o,
    output logic [31:0] job_reps_o,
    output logic [31:0] job_id_o,
    input  logic        done_i
);
    localparam logic [7:0] OffConf = 8'h00, OffNextId = 8'h44, OffDoneId = 8'h48,
                           OffDst = 8'hD0, OffSrc = 8'hD8, OffLen = 8'hE0, OffReps = 8'hF8;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, LAUNCH, RDATA} state_e;
    state_e state_q, state_d;

    logic [AxiIdWidth-1:0] id_q;
    logic [7:0]  off_q, len_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] conf_q, dst_q, src_q, length_q, reps_q;
    logic [31:0] next_id, done_id;

    function automatic logic mapped(input logic [7:0] off);
        case (off)
            OffConf, OffNextId, OffDoneId, OffDst, OffSrc, OffLen: return 1'b1;
            OffReps: return IsTwoD;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    // Both ID counters skip 0 on wrap so an ID of 0 never names a real job.
    function automatic logic [31:0] inc_id(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? 32'd1 : v + 32'd1;
    endfunction

    logic [7:0] aw_off, ar_off;
    logic       aw_err, ar_err, aw_hs, ar_hs, w_hs, job_hs, r_hs, launch_rd;
    logic [31:0] rd_val, w_lane;
    logic [3:0]  w_be;
    logic        unused_addr;

    assign aw_off    = axi_req_i.aw.addr[7:0];
    assign ar_off    = axi_req_i.ar.addr[7:0];
    assign aw_err    = !mapped(aw_off) || axi_req_i.aw.len != 8'd0 || axi_req_i.aw.size > 3'd2;
    assign ar_err    = !mapped(ar_off) || axi_req_i.ar.len != 8'd0 || axi_req_i.ar.size > 3'd2;
    assign aw_hs     = state_q == IDLE && axi_req_i.aw_valid;
    assign ar_hs     = state_q == IDLE && !axi_req_i.aw_valid && axi_req_i.ar_valid;
    assign w_hs      = state_q == WDATA && axi_req_i.w_valid;
    assign job_hs    = state_q == LAUNCH && job_ready_i;
    assign r_hs      = state_q == RDATA && axi_req_i.r_ready;
    assign launch_rd = !ar_err && ar_off == OffNextId && length_q != 32'd0;
    assign w_lane    = off_q[2] ? axi_req_i.w.data[AxiDataWidth-1:AxiDataWidth/2]
                                : axi_req_i.w.data[31:0];
    assign w_be      = off_q[2] ? axi_req_i.w.strb[7:4] : axi_req_i.w.strb[3:0];
    assign unused_addr = ^{axi_req_i.aw.addr[AxiAddrWidth-1:8], axi_req_i.ar.addr[AxiAddrWidth-1:8]};

    always_comb begin
        rd_val = 32'd0;
        case (ar_off)
            OffConf:   rd_val = conf_q;
            OffDoneId: rd_val = done_id;
            OffDst:    rd_val = dst_q;
            OffSrc:    rd_val = src_q;
            OffLen:    rd_val = length_q;
            OffReps:   rd_val = reps_q;
            default:   rd_val = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (axi_req_i.aw_valid) state_d = WDATA;
                    else if (axi_req_i.ar_valid) state_d = launch_rd ? LAUNCH : RDATA;
            WDATA:  if (w_hs && axi_req_i.w.last) state_d = WRESP;
            WRESP:  if (axi_req_i.b_ready) state_d = IDLE;
            LAUNCH: if (job_ready_i) state_d = RDATA;
            RDATA:  if (axi_req_i.r_ready && len_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            id_q     <= '0;
            off_q    <= 8'd0;
            len_q    <= 8'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            conf_q   <= 32'd0;
            dst_q    <= 32'd0;
            src_q    <= 32'd0;
            length_q <= 32'd0;
            reps_q   <= 32'd0;
            next_id  <= 32'd1;
            done_id  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q  <= axi_req_i.aw.id;
                off_q <= aw_off;
                len_q <= axi_req_i.aw.len;
                err_q <= aw_err;
            end
            if (ar_hs) begin
                id_q    <= axi_req_i.ar.id;
                off_q   <= ar_off;
                len_q   <= axi_req_i.ar.len;
                err_q   <= ar_err;
                rdata_q <= (ar_err || ar_off == OffNextId) ? 32'd0 : rd_val;
            end
            // Writes land only once the whole burst has drained; error bursts never land.
            if (w_hs && axi_req_i.w.last && !err_q) begin
                case (off_q)
                    OffConf: conf_q   <= merge(conf_q, w_lane, w_be);
                    OffDst:  dst_q    <= merge(dst_q, w_lane, w_be);
                    OffSrc:  src_q    <= merge(src_q, w_lane, w_be);
                    OffLen:  length_q <= merge(length_q, w_lane, w_be);
                    OffReps: if (IsTwoD) reps_q <= merge(reps_q, w_lane, w_be);
                    default: ;
                endcase
            end
            if (job_hs) begin
                rdata_q <= next_id;
                next_id <= inc_id(next_id);
            end
            if (r_hs && len_q != 8'd0) len_q <= len_q - 8'd1;
            if (done_i) done_id <= inc_id(done_id);
        end
    end

    logic launching;
    assign launching   = rst_ni && state_q == LAUNCH;
    assign job_valid_o = launching;
    assign job_src_o   = launching ? src_q : 32'd0;
    assign job_dst_o   = launching ? dst_q : 32'd0;
    assign job_len_o   = launching ? length_q : 32'd0;
    assign job_conf_o  = launching ? conf_q : 32'd0;
    assign job_reps_o  = (launching && IsTwoD) ? reps_q : 32'd0;
    assign job_id_o    = launching ? next_id : 32'd0;

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = rst_ni && state_q == IDLE;
        axi_rsp_o.ar_ready = rst_ni && state_q == IDLE && !axi_req_i.aw_valid;
        axi_rsp_o.w_ready  = rst_ni && state_q == WDATA;
        axi_rsp_o.b_valid  = rst_ni && state_q == WRESP;
        axi_rsp_o.b.id     = id_q;
        axi_rsp_o.b.resp   = err_q ? 2'b10 : 2'b00;
        axi_rsp_o.b.user   = {AxiUserWidth{1'b0}};
        axi_rsp_o.r_valid  = rst_ni && state_q == RDATA;
        axi_rsp_o.r.id     = id_q;
        axi_rsp_o.r.data   = {rdata_q, rdata_q};
        axi_rsp_o.r.resp   = err_q ? 2'b10 : 2'b00;
        axi_rsp_o.r.last   = len_q == 8'd0;
        axi_rsp_o.r.user   = {AxiUserWidth{1'b0}};
    end
endmodule
